// File: rtl/sample_capture_pkg.sv
// Shared types and sizing helpers for the sample_capture burst buffer.
// WAIT_TRIG exists only when SAMPLE_CAPTURE_TRIG_EN is defined.
package sample_capture_pkg;

    localparam int WORD_BITS = 16;
    localparam int BIT_CNT_W = 4;

`ifdef SAMPLE_CAPTURE_TRIG_EN
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_FILL      = 2'd2,
        ST_FULL      = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;
`endif

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sample_capture_ram.sv
// Simple dual-port word buffer: one write port, one registered read port.
// A same-address write is forwarded so a freshly written word is readable next cycle.
module sample_capture_ram
    import sample_capture_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = ptr_width(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WORD_BITS-1:0] wdata,
    input  logic                 re,
    input  logic [AW-1:0]        raddr,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/sample_capture.sv
// Burst capture of a 1-bit sample stream, packed MSB-first into 16-bit words.
// Define SAMPLE_CAPTURE_TRIG_EN to add the trig port and the WAIT_TRIG state.
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arm,
`ifdef SAMPLE_CAPTURE_TRIG_EN
    input  logic                          trig,
`endif
    input  logic                          din,
    input  logic                          rd,
    output logic [WORD_BITS-1:0]          dout,
    output logic                          busy,
    output logic                          done,
    output logic                          underflow,
    output logic [ptr_width(DEPTH_WORDS):0] count
);

    localparam int PW = ptr_width(DEPTH_WORDS);
    localparam int CW = PW + 1;

    state_t                 state_reg;
    logic [WORD_BITS-2:0]   shreg_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg;
    logic [PW-1:0]          wr_ptr_reg;
    logic [PW-1:0]          rd_ptr_reg;
    logic [CW-1:0]          count_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   underflow_reg;

    logic                   empty;
    logic                   pop_ok;
    logic                   pop_bad;
    logic                   word_we;
    logic [WORD_BITS-1:0]   word_wdata;
    logic                   last_word;
    logic [PW-1:0]          rd_addr;
    logic                   rd_en;

    always_comb begin
        empty = 1'b1;
        case (state_reg)
            ST_IDLE: empty = 1'b1;
            ST_FULL: empty = 1'b0;
            default: empty = (rd_ptr_reg == wr_ptr_reg);
        endcase
    end

    // arm takes priority over a same-cycle pop, which is then simply dropped
    assign pop_ok     = rd & ~arm & ~empty;
    assign pop_bad    = rd & ~arm & empty;
    assign word_we    = (state_reg == ST_FILL) && !arm && (bit_cnt_reg == {BIT_CNT_W{1'b1}});
    assign word_wdata = {shreg_reg, din};
    assign last_word  = (wr_ptr_reg == PW'(DEPTH_WORDS - 1));

    // Read the word that rd_ptr will point at after this edge; hold dout on an empty pop
    assign rd_addr = arm ? '0 : (rd_ptr_reg + PW'(pop_ok));
    assign rd_en   = (state_reg != ST_IDLE) && !pop_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            shreg_reg     <= '0;
            bit_cnt_reg   <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (arm) begin
`ifdef SAMPLE_CAPTURE_TRIG_EN
            state_reg     <= ST_WAIT_TRIG;
`else
            state_reg     <= ST_FILL;
`endif
            bit_cnt_reg   <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (pop_bad) begin
                underflow_reg <= 1'b1;
            end
            case (state_reg)
`ifdef SAMPLE_CAPTURE_TRIG_EN
                ST_WAIT_TRIG: begin
                    if (trig) begin
                        state_reg <= ST_FILL;
                    end
                end
`endif
                ST_FILL: begin
                    shreg_reg   <= {shreg_reg[WORD_BITS-3:0], din};
                    bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
                    if (word_we) begin
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                        count_reg  <= count_reg + CW'(1);
                        if (last_word) begin
                            state_reg <= ST_FULL;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    sample_capture_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (PW)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (word_we),
        .waddr(wr_ptr_reg),
        .wdata(word_wdata),
        .re   (rd_en),
        .raddr(rd_addr),
        .rdata(dout)
    );

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign underflow = underflow_reg;
    assign count     = count_reg;

endmodule

// File: doc/sample_capture.md
# sample_capture

Burst capture of the 1-bit limiter sample stream into a 16-bit-wide on-chip buffer for host readout. It sits downstream of the sample register that feeds the demodulators and upstream of the host bridge FIFO. On a CPU arm event it packs consecutive samples MSB-first into words until the buffer is full. The CPU then pops words one per read strobe onto the FIFO write-data mux.

## Interface
- DEPTH_WORDS, 1024: buffer depth in 16-bit words; power of two, 16 to 4096.
- clk  input  1  system clock; all logic is on posedge clk.
- rst  input  1  asynchronous active-low reset.
- arm  input  1  single-cycle start/restart capture; driven by the CPU sampler-reset event.
- trig  input  1  single-cycle capture trigger; driven by the C/A pause-resume pulse. Present only with SAMPLE_CAPTURE_TRIG_EN.
- din  input  1  registered limiter sample; one sample per clk.
- rd  input  1  single-cycle pop strobe; driven by the CPU get-samples event.
- dout  output  16  word at the read pointer; first captured sample is bit 15.
- busy  output  1  high while waiting for trigger or filling.
- done  output  1  buffer full; capture complete.
- underflow  output  1  sticky; set by a pop on an empty buffer.
- count  output  log2(DEPTH_WORDS)+1  number of words written since the last arm.

## Operation
- States:
  - IDLE: no capture in progress.
  - WAIT_TRIG: armed, waiting for trig (only with SAMPLE_CAPTURE_TRIG_EN).
  - FILL: samples are being packed and written.
  - FULL: buffer full; capture stopped.
- Transitions:
  - arm in any state: go to WAIT_TRIG, or directly to FILL when the macro is off. Also clears wr_ptr, rd_ptr, count, bit counter, underflow and done.
  - WAIT_TRIG, trig: go to FILL.
  - FILL, 16th bit of word DEPTH_WORDS-1 captured: go to FULL.
  - FULL: stay until the next arm.
- Packing in FILL:
  - Each clk: shreg <= {shreg[14:0], din}; the 4-bit bit counter increments.
  - When the bit counter is 15, the word {shreg[14:0], din} is written at wr_ptr. wr_ptr and count then increment.
- Read path:
  - Synchronous-read RAM, addressed by rd_ptr + rd.
  - A pop on a non-empty buffer increments rd_ptr modulo DEPTH_WORDS.
- Empty condition:
  - In FILL: rd_ptr == wr_ptr.
  - In IDLE after reset: always empty.
  - In FULL: never empty. rd_ptr wraps, so the buffer can be re-read indefinitely.
- Pop on empty: rd_ptr holds, dout holds, underflow is set.
- arm and rd in the same cycle: arm wins; the pop is discarded and underflow is not set.
- Reset values: state IDLE, all pointers and counters 0, dout 0, busy 0, done 0, underflow 0, count 0.

## Timing
- The first din captured is the one present in the cycle the state first reads FILL.
  - Macro off: the cycle after arm.
  - Macro on: the cycle after trig.
- Each word is written 16 clk after its first bit.
- A word written in cycle N is readable from cycle N+1.
- Pop latency:
  - dout reflects the popped-to word one clk after rd.
  - dout is valid during the rd cycle itself, because the consumer samples it combinationally alongside the strobe.
  - Back-to-back rd on consecutive cycles is supported.
- Status outputs are all registered. done rises the clk after the final write; busy falls in the same cycle.
- A capture of DEPTH_WORDS words takes 16·DEPTH_WORDS clk from entry to FILL until done.
- Reset is asynchronous on assertion. Release is synchronised externally; the block does not re-synchronise it.

## Configuration
- SAMPLE_CAPTURE_TRIG_EN defined:
  - The trig port and the WAIT_TRIG state exist.
  - Capture aligns to the C/A pause-resume epoch.
  - trig outside WAIT_TRIG is ignored.
- Not defined:
  - No trig port.
  - arm goes straight to FILL; the state encoding omits WAIT_TRIG.

## Structure
- Package sample_capture_pkg:
  - state enum.
  - WORD_BITS = 16.
  - bit-counter width.
  - function for the pointer width from DEPTH_WORDS.
- Sub-module sample_capture_ram:
  - simple dual-port, one write port and one synchronous-read port, 16 bits × DEPTH_WORDS.
  - Inferable to one block RAM at the default depth.
- FSM, packer and pointers live in the top-level sample_capture.

## Test plan
- Reset then rd ×1 -> dout 0x0000, underflow 1, count 0, busy 0.
- arm, din = alternating 1,0,… from the first FILL cycle, DEPTH_WORDS=16 -> after 256 clk: done 1, count 16. Sixteen pops read 0xAAAA each, and a 17th pop wraps to word 0.
- arm, din = 1 for 8 clk then 0 for 8 clk -> word 0 = 0xFF00. Popping in the cycle after the write gives 0xFF00 with underflow 0.
- arm, then rd 3 clk later (word not yet written) -> underflow 1, rd_ptr 0. A re-arm clears underflow.
- arm at bit 7 of word 5 mid-FILL -> count 0 next clk. The next word is packed from the first sample after re-entry, with no stale bits.
- SAMPLE_CAPTURE_TRIG_EN: arm, wait 100 clk, pulse trig -> busy 1 throughout, count 0 until trig. The first word contains the 16 samples starting the clk after trig.
